// File: rtl/ss_wbmem.sv
// Wishbone slave memory, 2^AW x 64-bit, with an optional wait-state lead-in and
// retry injection. It also has a backdoor port for loading and inspecting the array.
module ss_wbmem #(
  parameter int unsigned AW   = 8,
  parameter logic [31:0] BASE = 32'h0000_0000,
  parameter int unsigned WAIT = 0
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          wbs_cyc,
  input  logic          wbs_stb,
  input  logic          wbs_we,
  input  logic          wbs_cab,
  input  logic [3:0]    wbs_sel,
  input  logic [31:0]   wbs_adr,
  input  logic [31:0]   wbs_dat_i,
  input  logic [31:0]   wbs_dat64_i,
  output logic [31:0]   wbs_dat_o,
  output logic [31:0]   wbs_dat64_o,
  output logic          wbs_ack,
  output logic          wbs_rty,
  output logic          wbs_err,
  input  logic          rty_inject,
  input  logic          bd_we,
  input  logic [AW-1:0] bd_adr,
  input  logic [63:0]   bd_dat,
  output logic [63:0]   bd_q,
  output logic [15:0]   ack_cnt
);

  typedef enum logic [2:0] {StIdle, StWait, StXfer, StErr, StHold} state_e;

  localparam logic [3:0] WaitLast = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

  logic [63:0]   mem_q [2**AW];
  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          we_q, we_d;
  logic [15:0]   ack_cnt_q, ack_cnt_d;
  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic          req, hit, ack, rty, err;
  logic [63:0]   rd_word;

  // Byte selects and the sub-word address bits carry no information here.
  logic unused_bits;
  assign unused_bits = ^{wbs_sel, wbs_adr[2:0]};

  assign req = wbs_cyc & wbs_stb;
  assign hit = (wbs_adr[31:AW+3] == BASE[31:AW+3]);

  // State register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a dropped cyc always returns to idle.
  always_comb begin
    state_d = state_q;
    if (!wbs_cyc) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (wbs_stb) begin
            if (!hit) begin
              state_d = StErr;
            end else if (WAIT > 0) begin
              state_d = StWait;
            end else begin
              state_d = StXfer;
            end
          end
        end
        StWait: begin
          if (wait_cnt_q == WaitLast) state_d = StXfer;
        end
        StXfer: begin
          if (ack && !wbs_cab) state_d = StHold;
        end
        StErr:   state_d = StHold;
        StHold:  state_d = StHold;
        default: state_d = StIdle;
      endcase
    end
  end

  // Responses are gated with cyc&stb so a withdrawn request never sees one.
  always_comb begin
    ack = 1'b0;
    rty = 1'b0;
    err = 1'b0;
    if (req) begin
      unique case (state_q)
        StXfer: begin
          ack = ~rty_inject;
          rty = rty_inject;
        end
        StErr:   err = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    ptr_d      = ptr_q;
    we_d       = we_q;
    ack_cnt_d  = ack_cnt_q;
    wait_cnt_d = wait_cnt_q;
    if (state_q == StIdle && req) begin
      ptr_d      = wbs_adr[AW+2:3];
      we_d       = wbs_we;
      wait_cnt_d = '0;
    end
    if (state_q == StWait) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
    if (ack) begin
      ptr_d     = ptr_q + AW'(1);
      ack_cnt_d = ack_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ptr_q      <= '0;
      we_q       <= 1'b0;
      ack_cnt_q  <= '0;
      wait_cnt_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      we_q       <= we_d;
      ack_cnt_q  <= ack_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Array is never reset; the bus write is issued last so it wins a collision.
  always_ff @(posedge wb_clk_i) begin
    if (bd_we) begin
      mem_q[bd_adr] <= bd_dat;
    end
    if (ack && we_q) begin
      mem_q[ptr_q] <= {wbs_dat64_i, wbs_dat_i};
    end
  end

  assign rd_word     = mem_q[ptr_q];
  assign wbs_dat_o   = ack ? rd_word[31:0]  : 32'h0;
  assign wbs_dat64_o = ack ? rd_word[63:32] : 32'h0;
  assign wbs_ack     = ack;
  assign wbs_rty     = rty;
  assign wbs_err     = err;
  assign bd_q        = mem_q[bd_adr];
  assign ack_cnt     = ack_cnt_q;

endmodule
